baugh_mac_pipe: RTL

Pipelined, parametrised Baugh-Wooley multiply-accumulate unit. It is the sequential successor of the 8x8 combinational Baugh-Wooley multiplier and generalises it in three ways: operand width W, a per-transaction signed/unsigned mode, and an accumulator with clear and optional saturation. It sits between an operand source and a result sink, using valid/ready handshakes on both sides. Products are formed from an explicit Baugh-Wooley partial-product array; the `*` operator is not used.

---
 rtl/baugh_mac_pipe.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/baugh_mac_pipe.sv
// baugh_mac_pipe: three-stage Baugh-Wooley multiply-accumulate unit.
//   Stage 1 (PP)  : registers the W partial-product rows.
//   Stage 2 (SUM) : registers the modulo-2^(2W) sum of the rows (the product).
//   Stage 3 (ACC) : registers the product, the accumulator and the clamp flag.
// A single global advance enable moves every stage together; bubbles do not
// collapse, and a stalled result holds the whole pipe.
// Optional feature: define BAUGH_MAC_SAT_EN for a saturating accumulator;
// without it the accumulator wraps modulo 2^ACC_W and sat is tied low.
module baugh_mac_pipe #(
    parameter int unsigned W     = 8,
    parameter int unsigned ACC_W = 2 * W + 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    input  logic               sgn,
    input  logic               acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*W-1:0]     p,
    output logic [ACC_W-1:0]   acc,
    output logic               sat
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned XW = ACC_W - PW;

    // Global advance: the pipe moves unless a finished result is blocked.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ------------------------------------------------------------------
    // Stage 1: partial-product array
    // ------------------------------------------------------------------
    logic [W-1:0][PW-1:0] rows_c;
    logic [W-1:0][PW-1:0] s1_rows;
    logic                 s1_valid;
    logic                 s1_sgn;
    logic                 s1_clr;

    // Build row j from b[j]; in signed mode the terms pairing exactly one
    // sign bit are inverted and the two correction ones are placed in the
    // unused top positions of rows 0 and W-1.
    always_comb begin
        rows_c = '0;
        for (int j = 0; j < int'(W); j++) begin
            for (int i = 0; i < int'(W); i++) begin
                rows_c[j][i+j] = (a[i] & b[j]) ^
                                 (sgn && ((i == int'(W) - 1) != (j == int'(W) - 1)));
            end
        end
        if (sgn) begin
            rows_c[0][W]      = 1'b1;
            rows_c[W-1][PW-1] = 1'b1;
        end
    end

    // Stage 1 register: rows plus the beat's side-band bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_rows  <= '0;
            s1_valid <= 1'b0;
            s1_sgn   <= 1'b0;
            s1_clr   <= 1'b0;
        end else if (adv) begin
            s1_rows  <= rows_c;
            s1_valid <= in_valid;
            s1_sgn   <= sgn;
            s1_clr   <= acc_clr;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: row summation
    // ------------------------------------------------------------------
    logic [PW-1:0] sum_c;
    logic [PW-1:0] s2_sum;
    logic          s2_valid;
    logic          s2_sgn;
    logic          s2_clr;

    // Modulo-2^(2W) sum of all rows; the carry out of the top is discarded.
    always_comb begin
        sum_c = '0;
        for (int j = 0; j < int'(W); j++) begin
            sum_c = sum_c + s1_rows[j];
        end
    end

    // Stage 2 register: product bits plus side-band.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_sum   <= '0;
            s2_valid <= 1'b0;
            s2_sgn   <= 1'b0;
            s2_clr   <= 1'b0;
        end else if (adv) begin
            s2_sum   <= sum_c;
            s2_valid <= s1_valid;
            s2_sgn   <= s1_sgn;
            s2_clr   <= s1_clr;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: accumulate
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] base_c;
    logic [ACC_W-1:0] ext_c;
    logic [ACC_W-1:0] acc_next_c;

    // Accumulator base and the product extended in the beat's own mode.
    always_comb begin
        base_c = s2_clr ? '0 : acc;
        ext_c  = s2_sgn ? {{XW{s2_sum[PW-1]}}, s2_sum}
                        : {{XW{1'b0}}, s2_sum};
    end

`ifdef BAUGH_MAC_SAT_EN
    logic [ACC_W:0] wide_c;
    logic           sat_next_c;

    // One-bit-wider add; clamp to the signed or unsigned range on overflow.
    always_comb begin
        wide_c     = '0;
        acc_next_c = '0;
        sat_next_c = 1'b0;
        if (s2_sgn) begin
            wide_c = {base_c[ACC_W-1], base_c} + {ext_c[ACC_W-1], ext_c};
        end else begin
            wide_c = {1'b0, base_c} + {1'b0, ext_c};
        end
        acc_next_c = wide_c[ACC_W-1:0];
        if (s2_sgn && (wide_c[ACC_W] != wide_c[ACC_W-1])) begin
            sat_next_c = 1'b1;
            acc_next_c = wide_c[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};
        end else if (!s2_sgn && wide_c[ACC_W]) begin
            sat_next_c = 1'b1;
            acc_next_c = '1;
        end
    end

    // Clamp flag follows each valid beat into the result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat <= 1'b0;
        end else if (adv && s2_valid) begin
            sat <= sat_next_c;
        end
    end
`else
    // Wrapping accumulate; no clamp exists in this build.
    assign acc_next_c = base_c + ext_c;
    assign sat        = 1'b0;
`endif

    // Result registers; the accumulator doubles as the acc output and only
    // valid beats change it, bubbles just drop out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            p         <= '0;
            acc       <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                p   <= s2_sum;
                acc <= acc_next_c;
            end
        end
    end

endmodule
